// File: rtl/pdq_pipe_pkg.sv
// Shared definitions for the pdq pipeline control blocks.
package pdq_pipe_pkg;

    localparam int STALL_W_DEFAULT = 16;

    // Width needed to hold any occupancy value from 0 to depth inclusive.
    function automatic int count_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_pipeline_ctrl.sv
// Valid-bit controller for a chain of externally held register stages.
// Collapses bubbles, supports flush, and counts output-stall cycles.
module register_pipeline_ctrl
    import pdq_pipe_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int STALL_W = STALL_W_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      I_valid,
    output logic                      I_ready,
    output logic                      O_valid,
    input  logic                      O_ready,
    input  logic                      FLUSH,
    output logic [DEPTH-1:0]          CE,
    output logic [count_w(DEPTH)-1:0] COUNT,
    output logic [STALL_W-1:0]        STALL_CNT
);

    localparam int CW = count_w(DEPTH);

    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   rdy;
    logic [DEPTH-1:0]   shifted;
    logic [DEPTH-1:0]   v_next;
    logic [CW-1:0]      pop;
    logic [STALL_W-1:0] stall_cnt;
    logic               full_tail;
    logic               stalled;

    // A stage can load unless it and every stage after it are full while the output is blocked.
    always_comb begin
        full_tail = 1'b1;
        rdy       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            full_tail = full_tail & valid[i];
            rdy[i]    = ~full_tail | O_ready;
        end
    end

    assign shifted = (valid << 1) | DEPTH'(I_valid);
    assign v_next  = (shifted & rdy) | (valid & ~rdy);

    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pop = pop + CW'(valid[i]);
        end
    end

    // Valid bits still hold pre-reset contents during the reset cycle, so mask them at the outputs.
    assign CE        = rdy & {DEPTH{~FLUSH}};
    assign I_ready   = (rdy[0] | RESET) & ~FLUSH;
    assign O_valid   = valid[DEPTH-1] & ~FLUSH & ~RESET;
    assign COUNT     = RESET ? '0 : pop;
    assign STALL_CNT = stall_cnt;
    assign stalled   = O_valid & ~O_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
        end else if (FLUSH) begin
            valid <= '0;
        end else begin
            valid <= v_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: doc/register_pipeline_ctrl.md
REGISTER_PIPELINE_CTRL -- requirements
Module: register_pipeline_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of extracted register stages controlled; legal range 1..16.
REQ-002 SHALL have parameter STALL_W, default 16: stall counter width.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge; all state in this single domain.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port I_valid  input  1  upstream token present.
REQ-006 SHALL have port I_ready  output  1  stage 0 accepts this cycle.
REQ-007 SHALL have port O_valid  output  1  last stage holds a token.
REQ-008 SHALL have port O_ready  input  1  downstream accepts.
REQ-009 SHALL have port FLUSH  input  1  discard all in-flight tokens.
REQ-010 SHALL have port CE  output  DEPTH  per-stage register clock enable; CE[0] loads the input side, CE[DEPTH-1] the output stage.
REQ-011 SHALL have port COUNT  output  $clog2(DEPTH+1)  tokens currently held.
REQ-012 SHALL have port STALL_CNT  output  STALL_W  saturating count of output-stall cycles.

Function
REQ-013 SHALL keep one valid bit v[i] per stage.
REQ-014 SHALL compute rdy[DEPTH-1] = ~v[DEPTH-1] | O_ready and rdy[i] = ~v[i] | rdy[i+1], combinationally, for i < DEPTH-1 (bubble collapsing).
REQ-015 SHALL drive CE[i] = rdy[i] & ~FLUSH.
REQ-016 SHALL drive I_ready = rdy[0] & ~FLUSH and O_valid = v[DEPTH-1] & ~FLUSH.
REQ-017 SHALL, when CE[0], load v[0] <= I_valid.
REQ-018 SHALL, when CE[i] and i > 0, load v[i] <= v[i-1].
REQ-019 SHALL hold each stage whose CE is low.
REQ-020 SHALL have latency DEPTH: a token accepted at edge k appears as O_valid in the cycle after edge k+DEPTH-1, provided there is no stall.
REQ-021 SHALL sustain a throughput of one token per cycle while O_ready=1.
REQ-022 SHALL neither drop nor duplicate tokens: count accepted = count delivered + COUNT, between flushes.
REQ-023 SHALL clear all v[i] at the next edge when FLUSH=1; no handshake completes in a FLUSH cycle.
REQ-024 SHALL give FLUSH priority over all transfers.
REQ-025 SHALL drive COUNT = popcount(v), registered state only.
REQ-026 SHALL increment STALL_CNT on each cycle with O_valid & ~O_ready.
REQ-027 SHALL saturate STALL_CNT at 2^STALL_W-1 with no wrap.
REQ-028 SHALL leave STALL_CNT unaffected by FLUSH.
REQ-029 SHALL accept a new input and deliver an output in the same cycle when both handshakes fire.

Reset
REQ-030 SHALL clear all v[i] and STALL_CNT at the next rising CLK edge when RESET=1, including mid-stream.
REQ-031 SHALL, during RESET and in the first cycle after it, hold O_valid=0 and COUNT=0, and I_ready equal to ~FLUSH.
REQ-032 SHALL give RESET priority over FLUSH and all handshakes.

Structure
REQ-033 SHALL take STALL_W's default and a count-width helper function from the shared package pdq_pipe_pkg.
REQ-034 SHALL be a single module with no sub-modules; the data registers remain external and are driven by CE.

Verification (DEPTH=3 unless stated)
REQ-035 SHALL cover streaming: I_valid=1 and O_ready=1 from cycle 0 -> first O_valid in cycle 3, then one token per cycle, COUNT=3 steady, STALL_CNT=0.
REQ-036 SHALL cover backpressure: O_ready=0 while 5 tokens are offered -> 3 accepted, then I_ready=0, COUNT=3, STALL_CNT increments every cycle from cycle 3; raising O_ready releases all tokens in order.
REQ-037 SHALL cover bubble collapse: v=101, O_ready=0, I_valid=1 -> I_ready=1, CE=011, next v=111.
REQ-038 SHALL cover flush: COUNT=2 plus a 1-cycle FLUSH with I_valid=1 -> I_ready=0 and O_valid=0 in the FLUSH cycle, then COUNT=0 next cycle, STALL_CNT unchanged.
REQ-039 SHALL cover saturation: STALL_W=4 with a stall held 20 cycles -> STALL_CNT stops at 15.
REQ-040 SHALL cover reset mid-operation: RESET with COUNT=3 and STALL_CNT=7 -> next cycle COUNT=0, STALL_CNT=0, O_valid=0.
